// File: rtl/nxn_game_ctrl.sv
// N x N tic-tac-toe controller: validates human/AI moves, checks for a win or
// draw after every move and keeps saturating tallies across games.
module nxn_game_ctrl #(
  parameter int N     = 3,
  parameter int WIN_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               move_req,
  input  logic [3:0]         move_idx,
  input  logic               ai_en,
  input  logic               ai_valid,
  input  logic [N*N-1:0]     ai_move,
  input  logic               new_game,
  output logic [N*N-1:0]     x_state,
  output logic [N*N-1:0]     o_state,
  output logic [2:0]         status,
  output logic               err,
  output logic [WIN_W-1:0]   x_wins,
  output logic [WIN_W-1:0]   o_wins,
  output logic [WIN_W-1:0]   draws
);

  localparam int C = N * N;
  localparam logic [C-1:0]     ONE   = C'(1);
  localparam logic [WIN_W-1:0] W_ONE = WIN_W'(1);

  typedef enum logic [2:0] {
    X_TURN  = 3'd0,
    O_TURN  = 3'd1,
    AI_WAIT = 3'd2,
    CHECK   = 3'd3,
    X_WON   = 3'd4,
    O_WON   = 3'd5,
    DRAW    = 3'd6
  } state_t;

  state_t       state;
  logic         last_x;
  logic [1:0]   rst_sync;
  logic         hold;
  logic [C-1:0] occ, hum_oh, last_board;
  logic         hum_ok, ai_ok, line_win, full;

  // Handshake: move_req and ai_valid are single-cycle strobes with no ready;
  // a strobe outside the state that consumes it is dropped, a bad one in that
  // state raises err for the following cycle.

  // Release of clr is retimed so the board stays cleared for two more edges.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign hold = rst_sync[1];

  function automatic logic win_of(input logic [C-1:0] b);
    logic row_ok, col_ok, d1, d2, w;
    w  = 1'b0;
    d1 = 1'b1;
    d2 = 1'b1;
    for (int r = 0; r < N; r++) begin
      row_ok = 1'b1;
      col_ok = 1'b1;
      for (int c = 0; c < N; c++) begin
        row_ok = row_ok & b[r*N+c];
        col_ok = col_ok & b[c*N+r];
      end
      w  = w | row_ok | col_ok;
      d1 = d1 & b[r*N+r];
      d2 = d2 & b[r*N+(N-1-r)];
    end
    return w | d1 | d2;
  endfunction

  assign occ        = x_state | o_state;
  // An index past the board shifts the one-hot out to zero, which rejects it.
  assign hum_oh     = ONE << move_idx;
  assign hum_ok     = (hum_oh != '0) && ((hum_oh & occ) == '0);
  assign ai_ok      = (ai_move != '0) && ((ai_move & (ai_move - ONE)) == '0) &&
                      ((ai_move & occ) == '0);
  assign last_board = last_x ? x_state : o_state;
  assign line_win   = win_of(last_board);
  assign full       = &occ;
  assign status     = state;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= X_TURN;
      x_state <= '0;
      o_state <= '0;
      err     <= 1'b0;
      last_x  <= 1'b0;
      x_wins  <= '0;
      o_wins  <= '0;
      draws   <= '0;
    end else if (hold) begin
      state   <= X_TURN;
      x_state <= '0;
      o_state <= '0;
      err     <= 1'b0;
      last_x  <= 1'b0;
      x_wins  <= '0;
      o_wins  <= '0;
      draws   <= '0;
    end else if (new_game) begin
      state   <= X_TURN;
      x_state <= '0;
      o_state <= '0;
      err     <= 1'b0;
      last_x  <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        X_TURN: if (move_req) begin
          if (hum_ok) begin
            x_state <= x_state | hum_oh;
            last_x  <= 1'b1;
            state   <= CHECK;
          end else err <= 1'b1;
        end
        O_TURN: if (move_req) begin
          if (hum_ok) begin
            o_state <= o_state | hum_oh;
            last_x  <= 1'b0;
            state   <= CHECK;
          end else err <= 1'b1;
        end
        AI_WAIT: if (ai_valid) begin
          if (ai_ok) begin
            o_state <= o_state | ai_move;
            last_x  <= 1'b0;
            state   <= CHECK;
          end else err <= 1'b1;
        end
        CHECK: begin
          // A line completed by the board-filling move counts as a win.
          if (line_win) begin
            if (last_x) begin
              state <= X_WON;
              if (x_wins != '1) x_wins <= x_wins + W_ONE;
            end else begin
              state <= O_WON;
              if (o_wins != '1) o_wins <= o_wins + W_ONE;
            end
          end else if (full) begin
            state <= DRAW;
            if (draws != '1) draws <= draws + W_ONE;
          end else if (last_x) begin
            state <= ai_en ? AI_WAIT : O_TURN;
          end else begin
            state <= X_TURN;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_nxn_game_ctrl.sv
// Directed bench for nxn_game_ctrl: 3x3 default, 3x3 with 2-bit tallies and
// a 4x4 board, all driven from one shared stimulus stream.
module tb_nxn_game_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        move_req = 1'b0;
  logic [3:0]  move_idx = 4'd0;
  logic        ai_en = 1'b0;
  logic        ai_valid = 1'b0;
  logic [8:0]  ai_move = 9'd0;
  logic [15:0] ai_move_d = 16'd0;
  logic        new_game = 1'b0;

  logic [8:0]  x_state, o_state, x_state_b, o_state_b;
  logic [2:0]  status, status_b, status_d;
  logic        err, err_b, err_d;
  logic [3:0]  x_wins, o_wins, draws;
  logic [1:0]  x_wins_b, o_wins_b, draws_b;
  logic [15:0] x_state_d, o_state_d;
  logic [3:0]  x_wins_d, o_wins_d, draws_d;

  int n_tests = 0;
  int n_fail  = 0;

  nxn_game_ctrl #(.N(3), .WIN_W(4)) u_dut (
    .clk(clk), .clr(clr), .move_req(move_req), .move_idx(move_idx),
    .ai_en(ai_en), .ai_valid(ai_valid), .ai_move(ai_move), .new_game(new_game),
    .x_state(x_state), .o_state(o_state), .status(status), .err(err),
    .x_wins(x_wins), .o_wins(o_wins), .draws(draws)
  );

  nxn_game_ctrl #(.N(3), .WIN_W(2)) u_dut_w2 (
    .clk(clk), .clr(clr), .move_req(move_req), .move_idx(move_idx),
    .ai_en(ai_en), .ai_valid(ai_valid), .ai_move(ai_move), .new_game(new_game),
    .x_state(x_state_b), .o_state(o_state_b), .status(status_b), .err(err_b),
    .x_wins(x_wins_b), .o_wins(o_wins_b), .draws(draws_b)
  );

  nxn_game_ctrl #(.N(4), .WIN_W(4)) u_dut_n4 (
    .clk(clk), .clr(clr), .move_req(move_req), .move_idx(move_idx),
    .ai_en(ai_en), .ai_valid(ai_valid), .ai_move(ai_move_d), .new_game(new_game),
    .x_state(x_state_d), .o_state(o_state_d), .status(status_d), .err(err_d),
    .x_wins(x_wins_d), .o_wins(o_wins_d), .draws(draws_d)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: entered at a falling edge, return at the next falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic human(input int idx);
    move_req = 1'b1;
    move_idx = 4'(idx);
    @(negedge clk);
    move_req = 1'b0;
  endtask

  task automatic play(input int idx);
    human(idx);
    tick(1);
  endtask

  task automatic ai(input logic [8:0] v);
    ai_valid = 1'b1;
    ai_move  = v;
    @(negedge clk);
    ai_valid = 1'b0;
    ai_move  = 9'd0;
  endtask

  task automatic ng();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic x_row_win();
    play(0); play(3); play(1); play(4); play(2);
  endtask

  task automatic n4_anti_diag();
    play(3); play(0); play(6); play(1); play(9); play(2); human(12);
  endtask

  initial begin
    // Reset values while clr is held
    #2;
    check("rst_x_state", 32'(x_state), 32'h0);
    check("rst_o_state", 32'(o_state), 32'h0);
    check("rst_status",  32'(status),  32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_x_wins",  32'(x_wins),  32'd0);
    check("rst_draws",   32'(draws),   32'd0);

    // A move on the first edge after release must be ignored
    tick(2);
    clr = 1'b0;
    human(0);
    check("sync_first_edge", 32'(x_state), 32'h0);
    tick(2);

    // X wins on the top row
    play(0);
    check("turn_to_o", 32'(status), 32'd1);
    play(3); play(1); play(4);
    human(2);
    check("check_state", 32'(status), 32'd3);
    check("board_1cyc", 32'(x_state), 32'h007);
    tick(1);
    check("x_won",      32'(status),  32'd4);
    check("x_won_xs",   32'(x_state), 32'h007);
    check("x_won_os",   32'(o_state), 32'h018);
    check("x_wins_1",   32'(x_wins),  32'd1);
    human(8);
    check("term_ignore", 32'(x_state), 32'h007);
    check("term_no_err", 32'(err),     32'd0);

    ng();
    check("ng_board", 32'(x_state | o_state), 32'h0);
    check("ng_status", 32'(status), 32'd0);
    check("ng_keeps_wins", 32'(x_wins), 32'd1);

    // Rejected human moves
    play(4); play(0);
    human(4);
    check("occ_err",    32'(err),     32'd1);
    check("occ_xs",     32'(x_state), 32'h010);
    check("occ_status", 32'(status),  32'd0);
    tick(1);
    check("occ_err_drop", 32'(err), 32'd0);
    human(9);
    check("range_err",    32'(err),     32'd1);
    check("range_xs",     32'(x_state), 32'h010);
    check("range_status", 32'(status),  32'd0);
    tick(1);
    check("range_err_drop", 32'(err), 32'd0);
    ai(9'h002);
    check("ai_ignored_xturn", 32'(o_state), 32'h001);

    // AI opponent
    ng();
    ai_en = 1'b1;
    play(4);
    check("ai_wait", 32'(status), 32'd2);
    human(0);
    check("ai_wait_move_ign", 32'(x_state), 32'h010);
    check("ai_wait_no_err",   32'(err),     32'd0);
    ai(9'h003);
    check("ai_multi_err",  32'(err),     32'd1);
    check("ai_multi_stay", 32'(status),  32'd2);
    check("ai_multi_os",   32'(o_state), 32'h000);
    ai(9'h001);
    check("ai_ok_os",    32'(o_state), 32'h001);
    check("ai_ok_check", 32'(status),  32'd3);
    tick(1);
    check("ai_to_x", 32'(status), 32'd0);
    ai_en = 1'b0;

    // Draw
    ng();
    play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(6); play(8);
    check("draw_status", 32'(status),  32'd6);
    check("draws_1",     32'(draws),   32'd1);
    check("draw_xs",     32'(x_state), 32'h18D);
    check("draw_os",     32'(o_state), 32'h072);
    ng();
    check("draw_ng_board",  32'(x_state | o_state), 32'h0);
    check("draw_ng_status", 32'(status), 32'd0);
    check("draw_ng_draws",  32'(draws),  32'd1);

    // O wins on the middle row
    play(0); play(3); play(1); play(4); play(8); play(5);
    check("o_won",    32'(status), 32'd5);
    check("o_wins_1", 32'(o_wins), 32'd1);

    // Win on the board-filling move beats draw
    ng();
    play(0); play(1); play(2); play(4); play(5); play(3); play(7); play(6); play(8);
    check("full_win_status", 32'(status),   32'd4);
    check("full_win_draws",  32'(draws),    32'd1);
    check("full_win_wins",   32'(x_wins),   32'd2);
    check("w2_wins_2",       32'(x_wins_b), 32'd2);

    // Tally saturation on the 2-bit instance
    ng(); x_row_win();
    check("w2_wins_3", 32'(x_wins_b), 32'd3);
    ng(); x_row_win();
    check("w2_sat_a", 32'(x_wins_b), 32'd3);
    ng(); x_row_win();
    check("w2_sat_b", 32'(x_wins_b), 32'd3);
    check("w4_wins_5", 32'(x_wins), 32'd5);

    // 4x4 anti-diagonal win, then clr during CHECK
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(3);
    n4_anti_diag();
    check("n4_check",   32'(status_d),  32'd3);
    check("n4_xs",      32'(x_state_d), 32'h1248);
    tick(1);
    check("n4_x_won",   32'(status_d), 32'd4);
    check("n4_x_wins",  32'(x_wins_d), 32'd1);
    ng();
    n4_anti_diag();
    check("n4_check_2", 32'(status_d), 32'd3);
    clr = 1'b1;
    #1;
    check("n4_clr_xs",     32'(x_state_d), 32'h0);
    check("n4_clr_os",     32'(o_state_d), 32'h0);
    check("n4_clr_status", 32'(status_d),  32'd0);
    check("n4_clr_err",    32'(err_d),     32'd0);
    check("n4_clr_xwins",  32'(x_wins_d),  32'd0);
    check("n4_clr_owins",  32'(o_wins_d),  32'd0);
    check("n4_clr_draws",  32'(draws_d),   32'd0);
    tick(2);
    check("n4_clr_held_wins", 32'(x_wins_d), 32'd0);
    clr = 1'b0;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
